// File: rtl/cmp_pkg.sv
// Shared definitions for the frame extremum tracker.
//   fmf_state_t : frame FSM states (IDLE, RUN, DONE)
//   fmf_iw()    : index width needed to address positions 0..L-1
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fmf_state_t;

  function automatic int unsigned fmf_iw(input int unsigned l);
    return (l <= 2) ? 1 : $clog2(l);
  endfunction

endpackage

// File: rtl/NCS_using_generate_TCS.sv
// Unsigned N-bit magnitude comparator built from 2-bit slices.
//   a, b : operands (N must be even)
//   gt   : a > b
//   eq   : a == b
module NCS_using_generate_TCS #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         gt,
  output logic         eq
);

  localparam int unsigned NS = N / 2;

  logic [NS-1:0] slice_gt;
  logic [NS-1:0] slice_eq;

  for (genvar i = 0; i < NS; i++) begin : g_slice
    logic [1:0] sa;
    logic [1:0] sb;
    assign sa          = a[2*i +: 2];
    assign sb          = b[2*i +: 2];
    assign slice_gt[i] = (sa[1] & ~sb[1]) | (~(sa[1] ^ sb[1]) & sa[0] & ~sb[0]);
    assign slice_eq[i] = (sa == sb);
  end

  // The most significant unequal slice decides; scan from the top while
  // all higher slices are still equal.
  always_comb begin
    gt = 1'b0;
    eq = 1'b1;
    for (int unsigned k = 0; k < NS; k++) begin
      if (eq) begin
        gt = slice_gt[NS-1-k];
        eq = slice_eq[NS-1-k];
      end
    end
  end

endmodule

// File: rtl/frame_max_min_finder.sv
// Streaming max/min tracker over a frame of L unsigned S-bit samples.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : begin a new frame (honoured only when idle)
//   in_valid/in_data : sample handshake input, in_ready when accepting
//   busy             : frame in progress
//   done             : one-cycle pulse once results are final
//   max_val/max_idx  : largest sample and its (earliest) frame position
//   min_val/min_idx  : smallest sample and its (earliest) frame position
module frame_max_min_finder
  import cmp_pkg::*;
#(
  parameter  int unsigned S  = 8,
  parameter  int unsigned L  = 16,
  localparam int unsigned IW = fmf_iw(L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [S-1:0]  in_data,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic [S-1:0]  max_val,
  output logic [IW-1:0] max_idx,
  output logic [S-1:0]  min_val,
  output logic [IW-1:0] min_idx
);

  localparam logic [IW-1:0] LAST = IW'(L - 1);

  fmf_state_t    state;
  logic [IW-1:0] cnt;
  logic          max_gt;
  logic          unused_max_eq;
  logic          min_gt;
  logic          min_eq;

  NCS_using_generate_TCS #(.N(S)) u_cmp_max (
    .a  (in_data),
    .b  (max_val),
    .gt (max_gt),
    .eq (unused_max_eq)
  );

  NCS_using_generate_TCS #(.N(S)) u_cmp_min (
    .a  (in_data),
    .b  (min_val),
    .gt (min_gt),
    .eq (min_eq)
  );

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      max_val <= '0;
      max_idx <= '0;
      min_val <= '0;
      min_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            if (cnt == '0) begin
              max_val <= in_data;
              max_idx <= '0;
              min_val <= in_data;
              min_idx <= '0;
            end else begin
              // Strict compares so ties keep the earliest index.
              if (max_gt) begin
                max_val <= in_data;
                max_idx <= cnt;
              end
              if (!min_gt && !min_eq) begin
                min_val <= in_data;
                min_idx <= cnt;
              end
            end
            // cnt parks at L-1 on the last sample so it cannot wrap.
            if (cnt == LAST) begin
              state <= DONE;
            end else begin
              cnt <= cnt + IW'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_max_min_finder.md
# frame_max_min_finder

- Streaming extremum tracker that sits directly downstream of the generate-built N-bit magnitude comparator.
- After a `start`, it accepts a frame of exactly `L` unsigned `S`-bit samples over a valid/ready handshake.
- Each accepted sample is compared against the running maximum and minimum using two comparator instances.
- When the frame completes, it reports the max/min values, their frame indices and a one-cycle `done` pulse.

## Interface
- `S`, 8, sample width in bits; must be even (the comparator works in 2-bit slices).
- `L`, 16, frame length in samples; at least 2.
- `IW`, `$clog2(L)`, index width (derived; not overridden).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a new frame; sampled only in IDLE.
- `in_valid`  in  1  `in_data` carries a sample.
- `in_data`  in  S  unsigned sample.
- `in_ready`  out  1  block can accept a sample this cycle.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse when frame results are final.
- `max_val`  out  S  largest sample of the frame.
- `max_idx`  out  IW  frame position of `max_val`.
- `min_val`  out  S  smallest sample of the frame.
- `min_idx`  out  IW  frame position of `min_val`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`; clears `cnt` to 0.
  - RUN -> DONE on the accept of sample index L-1.
  - DONE -> IDLE unconditionally after one cycle.
- Accept = `in_valid && in_ready`. `in_ready` = (state == RUN). `busy` = (state == RUN).
- First accept of a frame (`cnt` == 0): loads `max_val` = `min_val` = `in_data`; `max_idx` = `min_idx` = 0.
- Later accepts:
  - max updates only if `in_data` > `max_val` (comparator GT=1).
  - min updates only if `in_data` < `min_val` (GT=0, EQ=0).
  - Ties keep the earliest index.
- `cnt` increments on each accept. After the last accept it must not wrap into a new frame.
- `start` while in RUN or DONE is ignored; `in_valid` outside RUN is ignored.
- Result outputs hold their value from `done` until the first accept of the next frame.
- Comparison is unsigned, full `S` bits. No arithmetic beyond the `cnt` increment (width IW, max value L-1).

## Timing
- Reset values: state IDLE; `in_ready`, `busy`, `done` = 0; `max_val`, `min_val`, `max_idx`, `min_idx`, `cnt` = 0.
- Comparator path is combinational: registers update on the same edge that accepts the sample, so there is zero extra pipeline latency.
- Results are visible on the outputs in the cycle after each accept.
- `start` seen in IDLE at edge k: RUN and `in_ready` = 1 from cycle k+1.
- The L-th accept at edge m gives DONE in cycle m+1, with `done` = 1 for exactly that cycle. IDLE follows at m+2, so the earliest next `start` is sampled at edge m+2.
- Gaps in `in_valid` stall the frame indefinitely; indices count accepted samples, not cycles.
- `rst_n` low mid-frame: immediate return to IDLE; all outputs go to reset values asynchronously; `done` is not asserted.
- `start` and `in_valid` asserted together in IDLE: only `start` takes effect; the sample is not accepted.

## Structure
- Shared package `cmp_pkg`:
  - state enum `fmf_state_t` (IDLE, RUN, DONE).
  - function computing IW from L.
- Sub-module: two instances of the existing comparator `NCS_using_generate_TCS #(S)`.
  - One compares `in_data` against `max_val`.
  - The other compares `in_data` against `min_val`.
- No other hierarchy. FSM, counter and result registers live in this module.

## Test plan
- S=8, L=4:
  - samples 5, 200, 17, 200 -> `max_val` 200, `max_idx` 1 (tie keeps first), `min_val` 5, `min_idx` 0; `done` high for exactly one cycle after the 4th accept.
  - all samples 0x80 -> max = min = 0x80, both indices 0.
  - samples 255, 0, 254, 1 with `in_valid` toggled every other cycle -> max 255 @0, min 0 @1; `done` asserted only after the 4th accept.
  - `start` pulsed during RUN and DONE -> no effect on `cnt`; exactly one `done` per frame.
- Reset mid-frame: drop `rst_n` after 2 accepts -> all outputs 0, no `done`. A new frame of 3, 9, 1, 9 -> max 9 @1, min 1 @2.
- S=16, L=16: ascending ramp 0..15 -> max 15 @15, min 0 @0. Descending ramp -> max @0, min @15.
